// File: rtl/kelvin_axi_rd_responder.sv
// AXI4 read-only slave serving INCR bursts from a backdoor-loaded word memory.
// Optional macro KELVIN_AXI_RD_BACKPRESSURE_EN adds LFSR-driven rvalid throttling.
module kelvin_axi_rd_responder #(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 128,
    parameter int IDWIDTH   = 6,
    parameter int MEM_DEPTH = 1024,
    parameter int CMD_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         arvalid,
    output logic                         arready,
    input  logic [IDWIDTH-1:0]           arid,
    input  logic [AWIDTH-1:0]            araddr,
    input  logic [7:0]                   arlen,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [IDWIDTH-1:0]           rid,
    output logic [DWIDTH-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DWIDTH-1:0]            mem_wdata
);
    localparam int BSH = $clog2(DWIDTH / 8);
    localparam int WIW = AWIDTH - BSH;
    localparam int MAW = $clog2(MEM_DEPTH);
    localparam int PW  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW  = $clog2(CMD_DEPTH + 1);
    localparam logic [WIW-1:0] DEPTH_W  = WIW'(MEM_DEPTH);
    localparam logic [PW-1:0]  LAST_PTR = PW'(CMD_DEPTH - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(CMD_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    logic [DWIDTH-1:0]  mem [MEM_DEPTH];
    logic [IDWIDTH-1:0] q_id   [CMD_DEPTH];
    logic [WIW-1:0]     q_word [CMD_DEPTH];
    logic [7:0]         q_len  [CMD_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               run, push, pop, step, present, stall, empty, in_range;
    state_t             state, state_nxt;
    logic [WIW-1:0]     cur_word, nxt_word;
    logic [7:0]         cur_beat, nxt_beat, cur_len, nxt_len;
    logic [IDWIDTH-1:0] cur_id, nxt_id;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^araddr[BSH-1:0];

    // Memory is never reset so preloaded contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign arready = run && (count != FULL_CNT);
    assign push    = arvalid && arready;
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr]   <= arid;
            q_word[wr_ptr] <= araddr[AWIDTH-1:BSH];
            q_len[wr_ptr]  <= arlen;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            run   <= 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        end
    end

`ifdef KELVIN_AXI_RD_BACKPRESSURE_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= 8'hA5;
        else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = BURST;
            BURST:   if (rvalid && rready && rlast && empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A BURST cycle with rvalid low means the current beat is held back by stall.
    always_comb begin
        pop     = 1'b0;
        step    = 1'b0;
        present = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    present = !stall;
                end
            end
            BURST: begin
                if (!rvalid) begin
                    present = !stall;
                end else if (rready) begin
                    if (!rlast) begin
                        step    = 1'b1;
                        present = !stall;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        present = !stall;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        nxt_word = cur_word;
        nxt_beat = cur_beat;
        nxt_len  = cur_len;
        nxt_id   = cur_id;
        if (pop) begin
            nxt_word = q_word[rd_ptr];
            nxt_beat = 8'd0;
            nxt_len  = q_len[rd_ptr];
            nxt_id   = q_id[rd_ptr];
        end else if (step) begin
            nxt_word = cur_word + 1'b1;
            nxt_beat = cur_beat + 8'd1;
        end
    end

    assign in_range = (nxt_word < DEPTH_W);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_word <= '0;
            cur_beat <= '0;
            cur_len  <= '0;
            cur_id   <= '0;
            rvalid   <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= 2'b00;
            rlast    <= 1'b0;
        end else begin
            if (pop || step) begin
                cur_word <= nxt_word;
                cur_beat <= nxt_beat;
                cur_len  <= nxt_len;
                cur_id   <= nxt_id;
            end
            if (present) begin
                rvalid <= 1'b1;
                rid    <= nxt_id;
                rlast  <= (nxt_beat == nxt_len);
                rresp  <= in_range ? 2'b00 : 2'b11;
                rdata  <= in_range ? mem[nxt_word[MAW-1:0]] : '0;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end
endmodule
